// File: rtl/wra_data_fifo.sv
// wra_data_fifo: word-in / byte-out data FIFO feeding the DMA/WRA loader.
// The host writes packed 32-bit words. The DMA stage reads single bytes,
// least-significant byte first. Each byte is registered, so it appears one
// cycle after the read is accepted.
// Optional feature macro: FIFO_ERR_EN adds the sticky ovf/udf error flags.
module wra_data_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic          flush,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW+2:0] byte_cnt
`ifdef FIFO_ERR_EN
  ,
  output logic          ovf,
  output logic          udf
`endif
);

  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [1:0]    bsel_q, bsel_d;
  logic [AW:0]   wcnt_q, wcnt_d;
  logic [7:0]    rd_data_q, rd_data_d;

  logic          wr_acc;
  logic          rd_acc;
  logic          word_done;
  logic [31:0]   head_word;
  logic [7:0]    head_byte;

  // Status is derived from registered state only; a read that frees a slot
  // does not let a same-cycle write through while full.
  assign full     = (wcnt_q == (AW+1)'(DEPTH));
  assign byte_cnt = {wcnt_q, 2'b00} - {{(AW+1){1'b0}}, bsel_q};
  assign empty    = (byte_cnt == '0);
  assign rd_data  = rd_data_q;

  assign wr_acc    = wr_en && !full && !flush;
  assign rd_acc    = rd_en && !empty && !flush;
  assign word_done = rd_acc && (bsel_q == 2'd3);
  assign head_word = mem[rptr_q];
  assign head_byte = head_word[{bsel_q, 3'b000} +: 8];

  // Next-state for pointers, occupancy and the output byte register.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    bsel_d    = bsel_q;
    wcnt_d    = wcnt_q;
    rd_data_d = rd_data_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      bsel_d = '0;
      wcnt_d = '0;
    end else begin
      if (wr_acc) begin
        wptr_d = wptr_q + 1'b1;
      end
      if (rd_acc) begin
        rd_data_d = head_byte;
        bsel_d    = bsel_q + 2'd1;
        if (word_done) begin
          rptr_d = rptr_q + 1'b1;
        end
      end
      case ({wr_acc, word_done})
        2'b10:   wcnt_d = wcnt_q + 1'b1;
        2'b01:   wcnt_d = wcnt_q - 1'b1;
        default: wcnt_d = wcnt_q;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      bsel_q    <= '0;
      wcnt_q    <= '0;
      rd_data_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      bsel_q    <= bsel_d;
      wcnt_q    <= wcnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Word storage; contents are not reset or flushed, only pointers are.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr_q] <= wr_data;
    end
  end

`ifdef FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Sticky error flags: set on a dropped write / ignored read, cleared by flush.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (flush) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (wr_en && full) ovf_d = 1'b1;
      if (rd_en && empty) udf_d = 1'b1;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

endmodule
